// File: rtl/shared_mult_pkg.sv
// Shared definitions for the shared-multiplier cluster: FSM states and slot sizing.
package shared_mult_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Slot counter width; a single lane still needs a one-bit slot port.
  function automatic int slot_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hw_mult_unsigned.sv
// Unsigned W x W -> 2W multiplier used for all half-width partial products.
module hw_mult_unsigned #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int PW = 2 * W;

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/shared_mult_cluster.sv
// Signed multiplier cluster: the high*high partial product of every lane is
// time-shared on one multiplier, the remaining partial products are per lane.
//
// state   | meaning
// IDLE    | waiting for start, ready high
// RUN     | slot walks 0..NUM_LANES-1, shared multiplier fills hh per lane
// DONE    | results loaded into c_out with out_valid; start here chains a batch
module shared_mult_cluster
  import shared_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 3
) (
  input  logic                                fast_clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     a_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     b_in,
  input  logic [NUM_LANES-1:0]                trunc,
  output logic                                ready,
  output logic                                out_valid,
  output logic [NUM_LANES*2*DATA_WIDTH-1:0]   c_out,
  output logic [slot_width(NUM_LANES)-1:0]    slot
);

  localparam int DW = DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = slot_width(NUM_LANES);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_LANES - 1);

  state_t        state, next_state;
  logic [SW-1:0] next_slot;
  logic          capture, hh_we, load_out;

  logic [NUM_LANES*HW-1:0] a_hi_all, b_hi_all;
  logic [HW-1:0]           sh_a, sh_b;
  logic [DW-1:0]           sh_p;
  logic [NUM_LANES*PW-1:0] c_next;

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      slot  <= '0;
    end else begin
      state <= next_state;
      slot  <= next_slot;
    end
  end

  always_comb begin
    next_state = state;
    next_slot  = slot;
    capture    = 1'b0;
    hh_we      = 1'b0;
    load_out   = 1'b0;
    ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          capture    = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        hh_we = 1'b1;
        if (slot == LAST_SLOT) begin
          next_state = ST_DONE;
          next_slot  = '0;
        end else begin
          next_slot = slot + 1'b1;
        end
      end
      ST_DONE: begin
        ready    = 1'b1;
        load_out = 1'b1;
        if (start) begin
          capture    = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Shared multiplier operands are selected by slot alone.
  always_comb begin
    sh_a = '0;
    sh_b = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (slot == SW'(i)) begin
        sh_a = a_hi_all[i*HW +: HW];
        sh_b = b_hi_all[i*HW +: HW];
      end
    end
  end

  hw_mult_unsigned #(.W(HW)) u_shared_mult (
    .a (sh_a),
    .b (sh_b),
    .p (sh_p)
  );

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DW-1:0] a_raw, b_raw, a_mag, b_mag;
    logic [HW-1:0] a_hi, a_lo, b_hi, b_lo;
    logic          sgn, trc;
    logic [DW-1:0] hh;
    logic [DW-1:0] p_hl, p_lh, p_ll;
    logic [PW-1:0] mag_p;

    assign a_raw = a_in[i*DW +: DW];
    assign b_raw = b_in[i*DW +: DW];
    // Two's-complement magnitude; the most negative value maps to 2^(DW-1).
    assign a_mag = a_raw[DW-1] ? (~a_raw + 1'b1) : a_raw;
    assign b_mag = b_raw[DW-1] ? (~b_raw + 1'b1) : b_raw;

    always_ff @(posedge fast_clk or posedge rst) begin
      if (rst) begin
        a_hi <= '0;
        a_lo <= '0;
        b_hi <= '0;
        b_lo <= '0;
        sgn  <= 1'b0;
        trc  <= 1'b0;
        hh   <= '0;
      end else begin
        if (capture) begin
          a_hi <= a_mag[DW-1:HW];
          a_lo <= a_mag[HW-1:0];
          b_hi <= b_mag[DW-1:HW];
          b_lo <= b_mag[HW-1:0];
          sgn  <= a_raw[DW-1] ^ b_raw[DW-1];
          trc  <= trunc[i];
        end
        if (hh_we && (slot == SW'(i))) begin
          hh <= sh_p;
        end
      end
    end

    assign a_hi_all[i*HW +: HW] = a_hi;
    assign b_hi_all[i*HW +: HW] = b_hi;

    hw_mult_unsigned #(.W(HW)) u_mult_hl (.a(a_hi), .b(b_lo), .p(p_hl));
    hw_mult_unsigned #(.W(HW)) u_mult_lh (.a(a_lo), .b(b_hi), .p(p_lh));
    hw_mult_unsigned #(.W(HW)) u_mult_ll (.a(a_lo), .b(b_lo), .p(p_ll));

    assign mag_p = (PW'(hh) << DW)
                 + ((PW'(p_hl) + PW'(p_lh)) << HW)
                 + (trc ? '0 : PW'(p_ll));

    assign c_next[i*PW +: PW] = sgn ? (~mag_p + 1'b1) : mag_p;
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      c_out     <= '0;
    end else begin
      out_valid <= load_out;
      if (load_out) begin
        c_out <= c_next;
      end
    end
  end

endmodule
